// File: rtl/va_pkg.sv
// Shared types, register map and reset constants for the vertex assembler.
package va_pkg;

  typedef enum logic [1:0] {
    LIST  = 2'd0,
    STRIP = 2'd1,
    FAN   = 2'd2
  } prim_mode_e;

  localparam logic [6:0] ADDR_ATTR0         = 7'h00;
  localparam logic [6:0] ADDR_ATTR1         = 7'h01;
  localparam logic [6:0] ADDR_VERTEX        = 7'h02;
  localparam logic [6:0] ADDR_INV_AREA      = 7'h03;
  localparam logic [6:0] ADDR_PRIM          = 7'h07;
  localparam logic [6:0] ADDR_ATTR_EXT_BASE = 7'h20;

  localparam int unsigned VTX_RESTART_BIT = 57;

  localparam logic [15:0] INV_AREA_RESET = 16'hFFFF;
  localparam logic [15:0] CULL_MAX       = 16'hFFFF;
  localparam prim_mode_e  MODE_RESET     = LIST;

  // Encoding 3 is reserved and behaves as a list.
  function automatic prim_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return STRIP;
      2'd2:    return FAN;
      default: return LIST;
    endcase
  endfunction

  // Channels 0/1 sit at the legacy addresses; the rest live at 0x20 + i.
  function automatic logic [6:0] attr_addr(input int unsigned i);
    if (i == 0) return ADDR_ATTR0;
    if (i == 1) return ADDR_ATTR1;
    return ADDR_ATTR_EXT_BASE + 7'(i);
  endfunction

endpackage

// File: rtl/va_tri_outreg.sv
// Valid/ready holding register for assembled triangles; also drives the
// command-side ready term so writes stall while a triangle is pending.
module va_tri_outreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         cmd_ready,
  output logic         tri_valid,
  input  logic         tri_ready,
  output logic [W-1:0] tri_data
);

  assign cmd_ready = !tri_valid || tri_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tri_valid <= 1'b0;
      tri_data  <= '0;
    end else if (load) begin
      tri_valid <= 1'b1;
      tri_data  <= load_data;
    end else if (tri_ready) begin
      tri_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vertex_assembler.sv
// Assembles list/strip/fan triangles from a per-vertex register-write stream.
// Define VA_CULL_DEGENERATE_EN to drop triangles with coincident vertices.
module vertex_assembler
  import va_pkg::*;
#(
  parameter int unsigned NUM_ATTR = 2,
  parameter int unsigned ATTR_W   = 32,
  parameter int unsigned XY_W     = 16,
  parameter int unsigned Z_W      = 25
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [6:0]                   cmd_addr,
  input  logic [63:0]                  cmd_wdata,
  output logic                         tri_valid,
  input  logic                         tri_ready,
  output logic [3*XY_W-1:0]            tri_x,
  output logic [3*XY_W-1:0]            tri_y,
  output logic [3*Z_W-1:0]             tri_z,
  output logic [3*NUM_ATTR*ATTR_W-1:0] tri_attr,
  output logic [15:0]                  tri_inv_area,
  output logic [1:0]                   prim_mode,
  output logic [1:0]                   vertex_count,
  output logic [15:0]                  cull_count
);

  localparam int unsigned AW = NUM_ATTR * ATTR_W;
  localparam int unsigned VW = 2 * XY_W + Z_W + AW;
  localparam int unsigned PW = 3 * VW + 16;
  localparam logic [AW-1:0] ATTR_RESET = AW'({ATTR_W{1'b1}});

  logic                            cmd_acc, kick, emit, load;
  logic [1:0]                      cnt, eff_cnt;
  logic                            parity, eff_par, swap;
  prim_mode_e                      mode;
  logic [NUM_ATTR-1:0][ATTR_W-1:0] cur_attr;
  logic [15:0]                     cur_inv_area;
  // Vertex layout, LSB first: X, Y, Z, attributes.
  logic [1:0][VW-1:0]              slot;
  logic [VW-1:0]                   va, vb, vc;
  logic [PW-1:0]                   tri_payload, tri_data;
  logic                            unused_wdata;

  assign unused_wdata = ^cmd_wdata[63:58];

  assign cmd_acc = cmd_valid && cmd_ready;
  assign kick    = cmd_acc && (cmd_addr == ADDR_VERTEX);
  assign eff_cnt = cmd_wdata[VTX_RESTART_BIT] ? 2'd0 : cnt;
  assign eff_par = cmd_wdata[VTX_RESTART_BIT] ? 1'b0 : parity;
  assign emit    = kick && (eff_cnt == 2'd2);
  assign swap    = (mode == STRIP) && eff_par;

  assign vc = {cur_attr, cmd_wdata[32 +: Z_W], cmd_wdata[16 +: XY_W], cmd_wdata[0 +: XY_W]};
  assign va = slot[swap];
  assign vb = slot[!swap];

  assign tri_payload = {cur_inv_area,
                        vc[VW-1 -: AW], vb[VW-1 -: AW], va[VW-1 -: AW],
                        vc[2*XY_W +: Z_W], vb[2*XY_W +: Z_W], va[2*XY_W +: Z_W],
                        vc[XY_W +: XY_W], vb[XY_W +: XY_W], va[XY_W +: XY_W],
                        vc[0 +: XY_W], vb[0 +: XY_W], va[0 +: XY_W]};

  assign tri_x        = tri_data[0 +: 3*XY_W];
  assign tri_y        = tri_data[3*XY_W +: 3*XY_W];
  assign tri_z        = tri_data[6*XY_W +: 3*Z_W];
  assign tri_attr     = tri_data[6*XY_W + 3*Z_W +: 3*AW];
  assign tri_inv_area = tri_data[PW-16 +: 16];
  assign prim_mode    = mode;
  assign vertex_count = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_attr     <= ATTR_RESET;
      cur_inv_area <= INV_AREA_RESET;
      mode         <= MODE_RESET;
      cnt          <= '0;
      parity       <= 1'b0;
      slot         <= '0;
    end else if (cmd_acc) begin
      for (int unsigned i = 0; i < NUM_ATTR; i++) begin
        if (cmd_addr == attr_addr(i)) cur_attr[i] <= cmd_wdata[ATTR_W-1:0];
      end
      if (cmd_addr == ADDR_INV_AREA) cur_inv_area <= cmd_wdata[15:0];
      if (cmd_addr == ADDR_PRIM) begin
        mode   <= decode_mode(cmd_wdata[1:0]);
        cnt    <= '0;
        parity <= 1'b0;
      end
      if (kick) begin
        case (eff_cnt)
          2'd0: begin
            slot[0] <= vc;
            cnt     <= 2'd1;
            parity  <= eff_par;
          end
          2'd1: begin
            slot[1] <= vc;
            cnt     <= 2'd2;
            parity  <= eff_par;
          end
          default: begin
            case (mode)
              STRIP: begin
                slot[0] <= slot[1];
                slot[1] <= vc;
                parity  <= !eff_par;
              end
              FAN:     slot[1] <= vc;
              default: cnt <= '0;
            endcase
          end
        endcase
      end
    end
  end

`ifdef VA_CULL_DEGENERATE_EN
  logic degenerate;

  // Coincidence is order-independent, so the raw slots are compared directly.
  assign degenerate = (slot[0][0 +: 2*XY_W] == slot[1][0 +: 2*XY_W]) ||
                      (slot[0][0 +: 2*XY_W] == vc[0 +: 2*XY_W]) ||
                      (slot[1][0 +: 2*XY_W] == vc[0 +: 2*XY_W]);
  assign load = emit && !degenerate;

  always_ff @(posedge clk) begin
    if (rst) begin
      cull_count <= '0;
    end else if (emit && degenerate && (cull_count != CULL_MAX)) begin
      cull_count <= cull_count + 16'd1;
    end
  end
`else
  assign load       = emit;
  assign cull_count = '0;
`endif

  va_tri_outreg #(
    .W(PW)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (tri_payload),
    .cmd_ready (cmd_ready),
    .tri_valid (tri_valid),
    .tri_ready (tri_ready),
    .tri_data  (tri_data)
  );

endmodule

// File: doc/vertex_assembler.md
Name: vertex_assembler

Overview:
- Parametrised successor to the fixed 3-vertex latch in the register file; assembles triangles from a per-vertex register-write stream.
- Supports list, strip and fan primitive topologies, a configurable number of per-vertex attribute channels, and ready/valid backpressure on both command and triangle interfaces.
- Sits between the command FIFO decode and the rasterizer setup stage; it owns vertex-related registers only.

Parameters:
- NUM_ATTR, 2, per-vertex attribute channels (1..8); channel 0 = colour.
- ATTR_W, 32, bits per attribute channel.
- XY_W, 16, X/Y width (12.4 fixed at default).
- Z_W, 25, depth width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  register write present.
- cmd_ready  out  1  write accepted this cycle when cmd_valid is also high.
- cmd_addr  in  7  register address.
- cmd_wdata  in  64  write data.
- tri_valid  out  1  triangle available.
- tri_ready  in  1  rasterizer accepts triangle.
- tri_x  out  3*XY_W  packed [2:0] X.
- tri_y  out  3*XY_W  packed [2:0] Y.
- tri_z  out  3*Z_W  packed [2:0] Z.
- tri_attr  out  3*NUM_ATTR*ATTR_W  packed [2:0][NUM_ATTR-1:0] attributes.
- tri_inv_area  out  16  1/area (0.16 fixed).
- prim_mode  out  2  current topology.
- vertex_count  out  2  vertices held (0..2).
- cull_count  out  16  degenerate triangles dropped.

Behaviour:
- Write acceptance
  - acc = cmd_valid && cmd_ready; cmd_ready = !tri_valid || tri_ready (combinational).
  - Stalls apply to all writes, so register ordering is preserved.
  - Unknown addresses are accepted and ignored.
- Address map
  - 0x00 ATTR0, 0x01 ATTR1, 0x20+i ATTRi (i = 2..NUM_ATTR-1); each latches current_attr[i] <= wdata[ATTR_W-1:0].
  - 0x03 INV_AREA: current_inv_area <= wdata[15:0].
  - 0x07 PRIM: mode <= wdata[1:0] (0 list, 1 strip, 2 fan, 3 treated as list); cnt <= 0; parity <= 0.
  - 0x02 VERTEX (kick): X = wdata[15:0], Y = [31:16], Z = [56:32], RESTART = [57].
- Kick processing
  - If RESTART=1, cnt and parity are treated as 0 before processing.
  - The new vertex is {X, Y, Z, current_attr[*]}. Two storage slots s0 and s1.
  - cnt=0: s0 <= new, cnt <= 1. cnt=1: s1 <= new, cnt <= 2.
  - cnt=2, list: emit (s0, s1, new); cnt <= 0.
  - cnt=2, strip: emit parity ? (s1, s0, new) : (s0, s1, new); s0 <= s1; s1 <= new; parity toggles; cnt stays 2.
  - cnt=2, fan: emit (s0, s1, new); s1 <= new; cnt stays 2.
- Emit
  - Output register loads the triangle plus current_inv_area; tri_valid = 1 the cycle after the accepting kick (latency 1).
  - tri_valid and all tri_* are held stable until tri_valid && tri_ready.
  - Accept and new emit in the same cycle: the register reloads and tri_valid stays 1. Accept with no new emit: tri_valid <= 0.
- Simultaneous events
  - PRIM write while tri_valid=1 is stalled like any other write.
  - RESTART on a kick that also completes a triangle cannot occur; RESTART sets cnt to 0 first, so that vertex becomes s0.
- Reset values
  - tri_valid 0; cnt 0; parity 0; mode list.
  - current_attr[0] 0xFFFFFFFF; other attrs 0; current_inv_area 0xFFFF.
  - tri_* data 0; cull_count 0.
  - Reset mid-handshake drops any pending triangle.

Optional Feature:
- Macro VA_CULL_DEGENERATE_EN.
- Defined:
  - An emitted triangle with any two vertices having equal X and Y is dropped: tri_valid is not set and the output register is unchanged.
  - Slot/cnt/parity still advance normally.
  - cull_count increments, saturating at 0xFFFF.
- Undefined: every triangle is emitted; cull_count is tied to 0.

Decomposition:
- Package va_pkg:
  - prim_mode_e (LIST, STRIP, FAN).
  - Address localparams (ADDR_ATTR0, ADDR_ATTR1, ADDR_VERTEX, ADDR_INV_AREA, ADDR_PRIM, ADDR_ATTR_EXT_BASE=0x20).
  - VTX_RESTART_BIT=57.
  - Reset constants.
- One sub-module, va_tri_outreg: the valid/ready holding register parametrised on payload width. It owns tri_valid and the cmd_ready term.

Test Plan:
- List, 6 kicks with ATTR0 = 0x11..0x66, tri_ready=1 -> 2 triangles; second is X (v3, v4, v5), attrs (0x44, 0x55, 0x66); vertex_count ends at 0.
- Strip, 5 kicks X = 1..5 -> 3 triangles: (1,2,3), (3,2,4), (3,4,5); kick 4 with RESTART=1 -> triangle (1,2,3) only, vertex_count 2.
- Fan, kicks X = 10, 20, 30, 40 -> (10,20,30), (10,30,40).
- tri_ready=0 while a triangle is pending -> cmd_ready=0 and a following ATTR0 write is not applied; one cycle of tri_ready=1 -> write accepted, triangle data unchanged until then.
- Reset asserted with tri_valid=1 and cnt=2 -> next cycle tri_valid=0, vertex_count=0, prim_mode=0, ATTR0 reset value 0xFFFFFFFF on the next triangle.
- VA_CULL_DEGENERATE_EN defined, list (5,5), (5,5), (9,1) -> no tri_valid, cull_count=1; undefined -> triangle emitted, cull_count=0.
